ram_loader: RTL and testbench

//   Upstream stage of Ram. Receives a byte-stream program image over a valid/ready port and writes it into RAM.

---
 rtl/ram_loader.sv | 132 +++++++++++++
 tb/tb_ram_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// Stream-to-RAM program loader: parses SYNC/LEN/ADDR/data/CHECKSUM frames
// and owns the RAM write port while a frame is in progress.
module ram_loader #(
   parameter int               RAM_DEPTH = 16,
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] SYNC_BYTE = 8'hA5
) (
   input  logic                          mclk,
   input  logic                          i_reset,
   input  logic                          mclk_en,
   input  logic                          i_rx_valid,
   input  logic [WIDTH-1:0]              i_rx_data,
   output logic                          o_rx_ready,
   input  logic [$clog2(RAM_DEPTH)-1:0]  i_cpu_address,
   output logic [$clog2(RAM_DEPTH)-1:0]  o_ram_address,
   output logic                          o_ram_load_enable,
   output logic [WIDTH-1:0]              o_ram_load_data,
   output logic                          o_prog_active,
   output logic                          o_done,
   output logic                          o_error
);

   localparam int ADDR_WIDTH = $clog2(RAM_DEPTH);
   localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(RAM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(RAM_DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_ADDR, S_DATA, S_WRITE, S_CHECK
   } state_t;

   state_t                state_q;
   logic [WIDTH-1:0]      cnt_q;
   logic [WIDTH-1:0]      sum_q;
   logic [WIDTH-1:0]      data_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  active_q;
   logic                  done_q;
   logic                  err_q;

   logic                  accept;
   logic                  len_bad;
   logic                  addr_bad;
   logic [WIDTH-1:0]      sum_d;
   logic [ADDR_WIDTH-1:0] addr_d;

   assign o_rx_ready = (state_q != S_WRITE);
   assign accept     = mclk_en & i_rx_valid & o_rx_ready;
   assign sum_d      = sum_q + i_rx_data;
   assign addr_d     = (addr_q == LAST_A) ? '0 : addr_q + 1'b1;
   assign len_bad    = (i_rx_data == '0) || (i_rx_data > DEPTH_W);
   assign addr_bad   = (i_rx_data >> ADDR_WIDTH) != '0;

   // Write strobe is dropped immediately on reset or a disabled cycle.
   assign o_ram_load_enable = (state_q == S_WRITE) & active_q
                              & mclk_en & ~i_reset;
   assign o_ram_address     = active_q ? addr_q : i_cpu_address;
   assign o_ram_load_data   = data_q;
   assign o_prog_active     = active_q;
   assign o_done            = done_q;
   assign o_error           = err_q;

   always_ff @(posedge mclk) begin
      if (i_reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         sum_q    <= '0;
         data_q   <= '0;
         addr_q   <= '0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else if (mclk_en) begin
         case (state_q)
            S_IDLE: begin
               if (accept && i_rx_data == SYNC_BYTE) begin
                  state_q  <= S_LEN;
                  active_q <= 1'b1;
                  done_q   <= 1'b0;
                  err_q    <= 1'b0;
                  sum_q    <= '0;
               end
            end
            S_LEN: begin
               if (accept) begin
                  if (len_bad) begin
                     err_q    <= 1'b1;
                     active_q <= 1'b0;
                     state_q  <= S_IDLE;
                  end else begin
                     cnt_q   <= i_rx_data;
                     state_q <= S_ADDR;
                  end
               end
            end
            S_ADDR: begin
               if (accept) begin
                  if (addr_bad) begin
                     err_q    <= 1'b1;
                     active_q <= 1'b0;
                     state_q  <= S_IDLE;
                  end else begin
                     addr_q  <= i_rx_data[ADDR_WIDTH-1:0];
                     state_q <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (accept) begin
                  data_q  <= i_rx_data;
                  sum_q   <= sum_d;
                  state_q <= S_WRITE;
               end
            end
            S_WRITE: begin
               addr_q  <= addr_d;
               cnt_q   <= cnt_q - 1'b1;
               state_q <= (cnt_q == WIDTH'(1)) ? S_CHECK : S_DATA;
            end
            S_CHECK: begin
               if (accept) begin
                  done_q   <= (i_rx_data == sum_q);
                  err_q    <= (i_rx_data != sum_q);
                  active_q <= 1'b0;
                  state_q  <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: RAM write scoreboard plus frame-status checks.
module tb_ram_loader;

   logic       mclk = 1'b0;
   logic       i_reset;
   logic       mclk_en;
   logic       i_rx_valid;
   logic [7:0] i_rx_data;
   logic       o_rx_ready;
   logic [3:0] i_cpu_address;
   logic [3:0] o_ram_address;
   logic       o_ram_load_enable;
   logic [7:0] o_ram_load_data;
   logic       o_prog_active;
   logic       o_done;
   logic       o_error;

   ram_loader dut (
      .mclk              (mclk),
      .i_reset           (i_reset),
      .mclk_en           (mclk_en),
      .i_rx_valid        (i_rx_valid),
      .i_rx_data         (i_rx_data),
      .o_rx_ready        (o_rx_ready),
      .i_cpu_address     (i_cpu_address),
      .o_ram_address     (o_ram_address),
      .o_ram_load_enable (o_ram_load_enable),
      .o_ram_load_data   (o_ram_load_data),
      .o_prog_active     (o_prog_active),
      .o_done            (o_done),
      .o_error           (o_error)
   );

   always #5 mclk = ~mclk;

   int          asserts = 0;
   int          fails   = 0;
   int          cyc     = 0;
   bit          en_mode = 1'b0;
   logic [7:0]  ram  [16];
   logic [7:0]  dbuf [16];
   logic [11:0] wr_log [$];
   logic [11:0] exp_q  [$];

   // One clock: settle, observe handshake and RAM write, advance to negedge.
   task automatic step(output bit got);
      #1;
      got = mclk_en && i_rx_valid && o_rx_ready;
      if (!i_reset && mclk_en && o_ram_load_enable) begin
         wr_log.push_back({o_ram_address, o_ram_load_data});
         ram[o_ram_address] = o_ram_load_data;
      end
      @(negedge mclk);
      cyc++;
      mclk_en = en_mode ? (cyc % 3 == 0) : 1'b1;
   endtask

   task automatic idle(input int n);
      bit g;
      repeat (n) step(g);
   endtask

   task automatic send(input logic [7:0] t);
      bit g;
      int n;
      n = 0;
      i_rx_valid = 1'b1;
      i_rx_data  = t;
      do begin
         step(g);
         n++;
      end while (!g && n < 60);
      asserts++;
      if (!g) begin
         fails++;
         $display("FAIL send_timeout token=%h not accepted in %0d cycles", t, n);
      end
   endtask

   task automatic send_frame(input logic [7:0] len, input logic [7:0] a,
                             input int n, input logic [7:0] cks);
      logic [3:0] wa;
      send(8'hA5);
      send(len);
      send(a);
      for (int i = 0; i < n; i++) begin
         wa = a[3:0] + 4'(i);
         exp_q.push_back({wa, dbuf[i]});
         send(dbuf[i]);
      end
      send(cks);
      i_rx_valid = 1'b0;
   endtask

   task automatic test_reset();
      i_reset = 1'b1;
      i_cpu_address = 4'h9;
      idle(2);
      i_reset = 1'b0;
      #1;
      asserts++;
      if ({o_prog_active, o_done, o_error, o_ram_load_enable} !== 4'b0) begin
         fails++;
         $display("FAIL reset_flags act/done/err/we=%b req 0000",
                  {o_prog_active, o_done, o_error, o_ram_load_enable});
      end
      asserts++;
      if (o_rx_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_ready got %b req 1", o_rx_ready);
      end
      asserts++;
      if (o_ram_address !== 4'h9) begin
         fails++;
         $display("FAIL reset_mux got %h req 9", o_ram_address);
      end
      idle(1);
   endtask

   task automatic test_load();
      logic [11:0] e, a;
      dbuf[0] = 8'h11; dbuf[1] = 8'h22; dbuf[2] = 8'h33;
      send(8'h3C);
      send_frame(8'h03, 8'h02, 3, 8'h66);
      asserts++;
      if ({o_done, o_error, o_prog_active} !== 3'b100) begin
         fails++;
         $display("FAIL load_status done/err/act=%b req 100",
                  {o_done, o_error, o_prog_active});
      end
      asserts++;
      if ({ram[2], ram[3], ram[4]} !== 24'h112233) begin
         fails++;
         $display("FAIL load_ram got %h req 112233", {ram[2], ram[3], ram[4]});
      end
      asserts++;
      if (o_ram_address !== i_cpu_address) begin
         fails++;
         $display("FAIL load_mux got %h req %h", o_ram_address, i_cpu_address);
      end
      asserts++;
      if (wr_log.size() != exp_q.size()) begin
         fails++;
         $display("FAIL load_wr_count got %0d req %0d", wr_log.size(), exp_q.size());
      end
      while (wr_log.size() > 0 && exp_q.size() > 0) begin
         a = wr_log.pop_front();
         e = exp_q.pop_front();
         asserts++;
         if (a !== e) begin
            fails++;
            $display("FAIL load_write addr/data got %h req %h", a, e);
         end
      end
      wr_log.delete();
      exp_q.delete();
   endtask

   task automatic test_wrap();
      logic [11:0] e, a;
      dbuf[0] = 8'hAA; dbuf[1] = 8'hBB;
      send_frame(8'h02, 8'h0F, 2, 8'h65);
      asserts++;
      if ({o_done, o_error} !== 2'b10) begin
         fails++;
         $display("FAIL wrap_status done/err=%b req 10", {o_done, o_error});
      end
      asserts++;
      if ({ram[15], ram[0]} !== 16'hAABB) begin
         fails++;
         $display("FAIL wrap_ram got %h req AABB", {ram[15], ram[0]});
      end
      asserts++;
      if (wr_log.size() != exp_q.size()) begin
         fails++;
         $display("FAIL wrap_wr_count got %0d req %0d", wr_log.size(), exp_q.size());
      end
      while (wr_log.size() > 0 && exp_q.size() > 0) begin
         a = wr_log.pop_front();
         e = exp_q.pop_front();
         asserts++;
         if (a !== e) begin
            fails++;
            $display("FAIL wrap_write addr/data got %h req %h", a, e);
         end
      end
      wr_log.delete();
      exp_q.delete();
   endtask

   task automatic test_bad_checksum();
      logic [11:0] e, a;
      dbuf[0] = 8'h5A;
      send_frame(8'h01, 8'h00, 1, 8'h00);
      asserts++;
      if ({o_done, o_error, o_prog_active} !== 3'b010) begin
         fails++;
         $display("FAIL cks_status done/err/act=%b req 010",
                  {o_done, o_error, o_prog_active});
      end
      asserts++;
      if (ram[0] !== 8'h5A) begin
         fails++;
         $display("FAIL cks_ram got %h req 5A", ram[0]);
      end
      asserts++;
      if (wr_log.size() != exp_q.size()) begin
         fails++;
         $display("FAIL cks_wr_count got %0d req %0d", wr_log.size(), exp_q.size());
      end
      while (wr_log.size() > 0 && exp_q.size() > 0) begin
         a = wr_log.pop_front();
         e = exp_q.pop_front();
         asserts++;
         if (a !== e) begin
            fails++;
            $display("FAIL cks_write addr/data got %h req %h", a, e);
         end
      end
      wr_log.delete();
      exp_q.delete();
   endtask

   task automatic test_bad_header();
      logic [7:0] hdr [6];
      hdr = '{8'hA5, 8'h00, 8'hA5, 8'h11, 8'hA5, 8'h01};
      for (int k = 0; k < 3; k++) begin
         send(hdr[2*k]);
         send(hdr[2*k+1]);
         if (k == 2) send(8'h20);
         i_rx_valid = 1'b0;
         asserts++;
         if ({o_error, o_done, o_prog_active, o_rx_ready} !== 4'b1001) begin
            fails++;
            $display("FAIL hdr%0d_status err/done/act/rdy=%b req 1001", k,
                     {o_error, o_done, o_prog_active, o_rx_ready});
         end
         idle(2);
      end
      asserts++;
      if (wr_log.size() != 0) begin
         fails++;
         $display("FAIL hdr_wr_count got %0d req 0", wr_log.size());
      end
      wr_log.delete();
   endtask

   task automatic test_mclk_en();
      logic [11:0] e, a;
      ram[2] = 8'h00; ram[3] = 8'h00; ram[4] = 8'h00;
      dbuf[0] = 8'h11; dbuf[1] = 8'h22; dbuf[2] = 8'h33;
      en_mode = 1'b1;
      send_frame(8'h03, 8'h02, 3, 8'h66);
      en_mode = 1'b0;
      idle(2);
      asserts++;
      if ({o_done, o_error} !== 2'b10) begin
         fails++;
         $display("FAIL en_status done/err=%b req 10", {o_done, o_error});
      end
      asserts++;
      if ({ram[2], ram[3], ram[4]} !== 24'h112233) begin
         fails++;
         $display("FAIL en_ram got %h req 112233", {ram[2], ram[3], ram[4]});
      end
      asserts++;
      if (wr_log.size() != exp_q.size()) begin
         fails++;
         $display("FAIL en_wr_count got %0d req %0d", wr_log.size(), exp_q.size());
      end
      while (wr_log.size() > 0 && exp_q.size() > 0) begin
         a = wr_log.pop_front();
         e = exp_q.pop_front();
         asserts++;
         if (a !== e) begin
            fails++;
            $display("FAIL en_write addr/data got %h req %h", a, e);
         end
      end
      wr_log.delete();
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      logic [11:0] e, a;
      i_cpu_address = 4'h7;
      send(8'hA5);
      send(8'h03);
      send(8'h02);
      exp_q.push_back({4'h2, 8'h11});
      send(8'h11);
      send(8'h22);
      i_reset = 1'b1;
      idle(1);
      i_reset = 1'b0;
      #1;
      asserts++;
      if ({o_prog_active, o_done, o_error, o_ram_load_enable} !== 4'b0) begin
         fails++;
         $display("FAIL rstmid_flags act/done/err/we=%b req 0000",
                  {o_prog_active, o_done, o_error, o_ram_load_enable});
      end
      asserts++;
      if (o_ram_address !== 4'h7) begin
         fails++;
         $display("FAIL rstmid_mux got %h req 7", o_ram_address);
      end
      i_rx_data = 8'h33;
      idle(6);
      i_rx_valid = 1'b0;
      asserts++;
      if (o_prog_active !== 1'b0) begin
         fails++;
         $display("FAIL rstmid_idle act got %b req 0", o_prog_active);
      end
      asserts++;
      if (wr_log.size() != exp_q.size()) begin
         fails++;
         $display("FAIL rstmid_wr_count got %0d req %0d", wr_log.size(), exp_q.size());
      end
      while (wr_log.size() > 0 && exp_q.size() > 0) begin
         a = wr_log.pop_front();
         e = exp_q.pop_front();
         asserts++;
         if (a !== e) begin
            fails++;
            $display("FAIL rstmid_write addr/data got %h req %h", a, e);
         end
      end
      wr_log.delete();
      exp_q.delete();
   endtask

   initial begin
      for (int i = 0; i < 16; i++) ram[i] = 8'h00;
      i_reset       = 1'b1;
      mclk_en       = 1'b1;
      i_rx_valid    = 1'b0;
      i_rx_data     = 8'h00;
      i_cpu_address = 4'h0;
      test_reset();
      test_load();
      test_wrap();
      test_bad_checksum();
      test_bad_header();
      test_mclk_en();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
